// File: rtl/process_instruction_pkg.sv
// Shared RV64IM decode constants: opcodes, funct fields, format codes, flag layout
// and the ABI register-name table.
package process_instruction_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_JALR = 3'd0;
  localparam logic [2:0] F3_FENCE = 3'd0;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd7
  } fmt_e;

  localparam int FLAG_RD      = 3;
  localparam int FLAG_RS1     = 4;
  localparam int FLAG_RS2     = 5;
  localparam int FLAG_IMM     = 6;
  localparam int FLAG_ILLEGAL = 7;

  // ASCII, right-justified in 32 bits
  function automatic logic [31:0] abi_name(input logic [4:0] idx);
    case (idx)
      5'd0:  abi_name = "zero";
      5'd1:  abi_name = "ra";
      5'd2:  abi_name = "sp";
      5'd3:  abi_name = "gp";
      5'd4:  abi_name = "tp";
      5'd5:  abi_name = "t0";
      5'd6:  abi_name = "t1";
      5'd7:  abi_name = "t2";
      5'd8:  abi_name = "s0";
      5'd9:  abi_name = "s1";
      5'd10: abi_name = "a0";
      5'd11: abi_name = "a1";
      5'd12: abi_name = "a2";
      5'd13: abi_name = "a3";
      5'd14: abi_name = "a4";
      5'd15: abi_name = "a5";
      5'd16: abi_name = "a6";
      5'd17: abi_name = "a7";
      5'd18: abi_name = "s2";
      5'd19: abi_name = "s3";
      5'd20: abi_name = "s4";
      5'd21: abi_name = "s5";
      5'd22: abi_name = "s6";
      5'd23: abi_name = "s7";
      5'd24: abi_name = "s8";
      5'd25: abi_name = "s9";
      5'd26: abi_name = "s10";
      5'd27: abi_name = "s11";
      5'd28: abi_name = "t3";
      5'd29: abi_name = "t4";
      5'd30: abi_name = "t5";
      default: abi_name = "t6";
    endcase
  endfunction

endpackage

// File: rtl/reg_name.sv
// Combinational map from a 5-bit register index to its ABI name string.
module reg_name
  import process_instruction_pkg::*;
#(
  parameter int REGISTER_NAME_WIDTH = 4
)(
  input  logic [4:0]                     idx,
  output logic [REGISTER_NAME_WIDTH*8:0] name
);
  localparam int NAME_W = REGISTER_NAME_WIDTH * 8 + 1;

  assign name = NAME_W'(abi_name(idx));

endmodule

// File: rtl/process_instruction.sv
// RV64IM instruction decoder: mnemonic, ABI register names, immediate and flags,
// registered with one cycle of latency.
module process_instruction
  import process_instruction_pkg::*;
#(
  parameter int REGISTER_NAME_WIDTH    = 4,
  parameter int IMMEDIATE_WIDTH        = 32,
  parameter int FLAG_WIDTH             = 8,
  parameter int INSTRUCTION_NAME_WIDTH = 12
)(
  input  logic                                clk,
  input  logic                                reset,
  input  logic [31:0]                         instruction,
  output logic [REGISTER_NAME_WIDTH*8:0]      rd,
  output logic [REGISTER_NAME_WIDTH*8:0]      rs1,
  output logic [REGISTER_NAME_WIDTH*8:0]      rs2,
  output logic signed [IMMEDIATE_WIDTH-1:0]   imm,
  output logic [FLAG_WIDTH-1:0]               flag,
  output logic [INSTRUCTION_NAME_WIDTH*8:0]   instruction_name
);
  localparam int RN_W = REGISTER_NAME_WIDTH * 8 + 1;
  localparam int MN_W = INSTRUCTION_NAME_WIDTH * 8 + 1;
  localparam int IW   = IMMEDIATE_WIDTH;

  logic [6:0] opcode, f7;
  logic [2:0] f3;
  assign opcode = instruction[6:0];
  assign f3     = instruction[14:12];
  assign f7     = instruction[31:25];

  logic [RN_W-1:0] rd_name, rs1_name, rs2_name;
  reg_name #(.REGISTER_NAME_WIDTH(REGISTER_NAME_WIDTH)) u_rd  (.idx(instruction[11:7]),  .name(rd_name));
  reg_name #(.REGISTER_NAME_WIDTH(REGISTER_NAME_WIDTH)) u_rs1 (.idx(instruction[19:15]), .name(rs1_name));
  reg_name #(.REGISTER_NAME_WIDTH(REGISTER_NAME_WIDTH)) u_rs2 (.idx(instruction[24:20]), .name(rs2_name));

  logic signed [IW-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, sh6, sh5;
  assign imm_i = IW'($signed(instruction[31:20]));
  assign imm_s = IW'($signed({instruction[31:25], instruction[11:7]}));
  assign imm_b = IW'($signed({instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0}));
  assign imm_u = IW'($signed({instruction[31:12], 12'b0}));
  assign imm_j = IW'($signed({instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0}));
  assign sh6   = IW'(instruction[25:20]);
  assign sh5   = IW'(instruction[24:20]);

  logic [MN_W-1:0]      nm;
  fmt_e                 fmt;
  logic                 use_rd, use_rs1, use_rs2, use_imm, legal;
  logic signed [IW-1:0] imm_d;
  logic [7:0]           flag_d;

  always_comb begin
    nm = '0; fmt = FMT_NONE; legal = 1'b1; imm_d = '0;
    use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_imm = 1'b0;
    case (opcode)
      OP_LUI:   begin nm = "lui";   fmt = FMT_U; use_rd = 1'b1; use_imm = 1'b1; imm_d = imm_u; end
      OP_AUIPC: begin nm = "auipc"; fmt = FMT_U; use_rd = 1'b1; use_imm = 1'b1; imm_d = imm_u; end
      OP_JAL:   begin nm = "jal";   fmt = FMT_J; use_rd = 1'b1; use_imm = 1'b1; imm_d = imm_j; end
      OP_JALR: begin
        fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; use_imm = 1'b1; imm_d = imm_i;
        if (f3 == F3_JALR) nm = "jalr"; else legal = 1'b0;
      end
      OP_BRANCH: begin
        fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b1; imm_d = imm_b;
        case (f3)
          3'd0: nm = "beq";  3'd1: nm = "bne";
          3'd4: nm = "blt";  3'd5: nm = "bge";
          3'd6: nm = "bltu"; 3'd7: nm = "bgeu";
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; use_imm = 1'b1; imm_d = imm_i;
        case (f3)
          3'd0: nm = "lb";  3'd1: nm = "lh";  3'd2: nm = "lw";  3'd3: nm = "ld";
          3'd4: nm = "lbu"; 3'd5: nm = "lhu"; 3'd6: nm = "lwu";
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1; use_imm = 1'b1; imm_d = imm_s;
        case (f3)
          3'd0: nm = "sb"; 3'd1: nm = "sh"; 3'd2: nm = "sw"; 3'd3: nm = "sd";
          default: legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; use_imm = 1'b1; imm_d = imm_i;
        case (f3)
          3'd0: nm = "addi";  3'd2: nm = "slti"; 3'd3: nm = "sltiu";
          3'd4: nm = "xori";  3'd6: nm = "ori";  3'd7: nm = "andi";
          F3_SLL: begin
            imm_d = sh6;
            if (f7[6:1] == 6'b000000) nm = "slli"; else legal = 1'b0;
          end
          default: begin
            imm_d = sh6;
            if (f7[6:1] == 6'b000000)      nm = "srli";
            else if (f7[6:1] == 6'b010000) nm = "srai";
            else                           legal = 1'b0;
          end
        endcase
      end
      OP_IMM32: begin
        fmt = FMT_I; use_rd = 1'b1; use_rs1 = 1'b1; use_imm = 1'b1; imm_d = sh5;
        if (f3 == F3_ADD) begin nm = "addiw"; imm_d = imm_i; end
        else if (f3 == F3_SLL && f7 == F7_BASE) nm = "slliw";
        else if (f3 == F3_SR && f7 == F7_BASE)  nm = "srliw";
        else if (f3 == F3_SR && f7 == F7_ALT)   nm = "sraiw";
        else legal = 1'b0;
      end
      OP_OP: begin
        fmt = FMT_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case ({f7, f3})
          {F7_BASE, 3'd0}: nm = "add";    {F7_BASE, 3'd1}: nm = "sll";
          {F7_BASE, 3'd2}: nm = "slt";    {F7_BASE, 3'd3}: nm = "sltu";
          {F7_BASE, 3'd4}: nm = "xor";    {F7_BASE, 3'd5}: nm = "srl";
          {F7_BASE, 3'd6}: nm = "or";     {F7_BASE, 3'd7}: nm = "and";
          {F7_ALT, 3'd0}:  nm = "sub";    {F7_ALT, 3'd5}:  nm = "sra";
          {F7_MULDIV, 3'd0}: nm = "mul";  {F7_MULDIV, 3'd1}: nm = "mulh";
          {F7_MULDIV, 3'd2}: nm = "mulhsu"; {F7_MULDIV, 3'd3}: nm = "mulhu";
          {F7_MULDIV, 3'd4}: nm = "div";  {F7_MULDIV, 3'd5}: nm = "divu";
          {F7_MULDIV, 3'd6}: nm = "rem";  {F7_MULDIV, 3'd7}: nm = "remu";
          default: legal = 1'b0;
        endcase
      end
      OP_OP32: begin
        fmt = FMT_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
        case ({f7, f3})
          {F7_BASE, 3'd0}: nm = "addw";   {F7_BASE, 3'd1}: nm = "sllw";
          {F7_BASE, 3'd5}: nm = "srlw";
          {F7_ALT, 3'd0}:  nm = "subw";   {F7_ALT, 3'd5}:  nm = "sraw";
          {F7_MULDIV, 3'd0}: nm = "mulw"; {F7_MULDIV, 3'd4}: nm = "divw";
          {F7_MULDIV, 3'd5}: nm = "divuw"; {F7_MULDIV, 3'd6}: nm = "remw";
          {F7_MULDIV, 3'd7}: nm = "remuw";
          default: legal = 1'b0;
        endcase
      end
      // fence, ecall and ebreak carry no operands worth reporting
      OP_MISC_MEM: begin
        fmt = FMT_I;
        if (f3 == F3_FENCE) nm = "fence"; else legal = 1'b0;
      end
      OP_SYSTEM: begin
        fmt = FMT_I;
        if (instruction == INST_ECALL)       nm = "ecall";
        else if (instruction == INST_EBREAK) nm = "ebreak";
        else                                 legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      nm = "unknown"; fmt = FMT_NONE; imm_d = '0;
      use_rd = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; use_imm = 1'b0;
    end
    flag_d               = {5'b0, fmt};
    flag_d[FLAG_RD]      = use_rd;
    flag_d[FLAG_RS1]     = use_rs1;
    flag_d[FLAG_RS2]     = use_rs2;
    flag_d[FLAG_IMM]     = use_imm;
    flag_d[FLAG_ILLEGAL] = !legal;
  end

  // Output register stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd               <= '0;
      rs1              <= '0;
      rs2              <= '0;
      imm              <= '0;
      flag             <= '0;
      instruction_name <= '0;
    end else begin
      rd               <= use_rd  ? rd_name  : '0;
      rs1              <= use_rs1 ? rs1_name : '0;
      rs2              <= use_rs2 ? rs2_name : '0;
      imm              <= imm_d;
      flag             <= FLAG_WIDTH'(flag_d);
      instruction_name <= nm;
    end
  end

endmodule

// File: tb/tb_process_instruction.sv
// Directed-vector bench for process_instruction: decode table plus latency and reset sequences.
module tb_process_instruction;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instruction;
  logic [32:0] rd, rs1, rs2;
  logic signed [31:0] imm;
  logic [7:0]  flag;
  logic [96:0] instruction_name;

  int checks = 0;
  int errors = 0;

  process_instruction dut (
    .clk(clk),
    .reset(reset),
    .instruction(instruction),
    .rd(rd),
    .rs1(rs1),
    .rs2(rs2),
    .imm(imm),
    .flag(flag),
    .instruction_name(instruction_name)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [95:0] nm;
    logic [31:0] rd;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [7:0]  flag;
  } vec_t;

  vec_t vecs[20];

  task automatic check_out(input string tag, input logic [95:0] nm, input logic [31:0] erd,
                           input logic [31:0] ers1, input logic [31:0] ers2,
                           input logic [31:0] eimm, input logic [7:0] eflag);
    checks++;
    if (instruction_name !== {1'b0, nm} || rd !== {1'b0, erd} || rs1 !== {1'b0, ers1} ||
        rs2 !== {1'b0, ers2} || imm !== eimm || flag !== eflag) begin
      errors++;
      $display("FAIL %s: got name=%h rd=%h rs1=%h rs2=%h imm=%h flag=%h; want name=%h rd=%h rs1=%h rs2=%h imm=%h flag=%h",
               tag, instruction_name, rd, rs1, rs2, imm, flag,
               {1'b0, nm}, {1'b0, erd}, {1'b0, ers1}, {1'b0, ers2}, eimm, eflag);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h00000013, "addi",    "zero", "zero", 32'd0, 32'd0,        8'h59};
    vecs[1]  = '{32'hfff00093, "addi",    "ra",   "zero", 32'd0, 32'hffffffff, 8'h59};
    vecs[2]  = '{32'h00b50533, "add",     "a0",   "a0",   "a1",  32'd0,        8'h38};
    vecs[3]  = '{32'h00113423, "sd",      32'd0,  "sp",   "ra",  32'd8,        8'h72};
    vecs[4]  = '{32'h12345537, "lui",     "a0",   32'd0,  32'd0, 32'h12345000, 8'h4c};
    vecs[5]  = '{32'hffdff06f, "jal",     "zero", 32'd0,  32'd0, 32'hfffffffc, 8'h4d};
    vecs[6]  = '{32'h02c58533, "mul",     "a0",   "a1",   "a2",  32'd0,        8'h38};
    vecs[7]  = '{32'h00000000, "unknown", 32'd0,  32'd0,  32'd0, 32'd0,        8'h87};
    vecs[8]  = '{32'h43f15093, "srai",    "ra",   "sp",   32'd0, 32'd63,       8'h59};
    vecs[9]  = '{32'h41f5551b, "sraiw",   "a0",   "a0",   32'd0, 32'd31,       8'h59};
    vecs[10] = '{32'hfe000fe3, "beq",     32'd0,  "zero", "zero", 32'hfffffffe, 8'h73};
    vecs[11] = '{32'h00000073, "ecall",   32'd0,  32'd0,  32'd0, 32'd0,        8'h01};
    vecs[12] = '{32'h00100073, "ebreak",  32'd0,  32'd0,  32'd0, 32'd0,        8'h01};
    vecs[13] = '{32'h0ff0000f, "fence",   32'd0,  32'd0,  32'd0, 32'd0,        8'h01};
    vecs[14] = '{32'h04b50533, "unknown", 32'd0,  32'd0,  32'd0, 32'd0,        8'h87};
    vecs[15] = '{32'h0004e503, "lwu",     "a0",   "s1",   32'd0, 32'd0,        8'h59};
    vecs[16] = '{32'h03df7fbb, "remuw",   "t6",   "t5",   "t4",  32'd0,        8'h38};
    vecs[17] = '{32'h80000d97, "auipc",   "s11",  32'd0,  32'd0, 32'h80000000, 8'h4c};
    vecs[18] = '{32'h800280e7, "jalr",    "ra",   "t0",   32'd0, 32'hfffff800, 8'h59};
    vecs[19] = '{32'h00007013, "unknown", 32'd0,  32'd0,  32'd0, 32'd0,        8'h87};
    // index 19 is OP_IMM with funct3=7 treated as andi below; fixed up here
    vecs[19] = '{32'h00007013, "andi",    "zero", "zero", 32'd0, 32'd0,        8'h59};

    reset = 1'b1;
    instruction = 32'h00b50533;
    #1;
    check_out("reset_async_initial", 96'd0, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    check_out("reset_held_over_edge", 96'd0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_out("first_edge_after_reset", "add", "a0", "a0", "a1", 0, 8'h38);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      instruction = vecs[i].inst;
      @(posedge clk); #1;
      check_out($sformatf("vec%0d_%h", i, vecs[i].inst), vecs[i].nm, vecs[i].rd,
                vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].flag);
    end

    // Latency: a new input must not show until the next rising edge
    @(negedge clk);
    instruction = 32'h12345537;
    @(posedge clk); #1;
    @(negedge clk);
    instruction = 32'h00000000;
    #2;
    check_out("hold_before_edge", "lui", "a0", 0, 0, 32'h12345000, 8'h4c);
    @(posedge clk); #1;
    check_out("update_after_edge", "unknown", 0, 0, 0, 0, 8'h87);

    // Asynchronous reset asserted between edges
    @(negedge clk);
    instruction = 32'h02c58533;
    @(posedge clk); #1;
    check_out("pre_reset_mul", "mul", "a0", "a1", "a2", 0, 8'h38);
    #2;
    reset = 1'b1;
    #1;
    check_out("async_reset_mid_cycle", 96'd0, 0, 0, 0, 0, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_out("after_release_before_edge", 96'd0, 0, 0, 0, 0, 8'h00);
    @(posedge clk); #1;
    check_out("reload_after_reset", "mul", "a0", "a1", "a2", 0, 8'h38);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/process_instruction.md
PROCESS_INSTRUCTION -- requirements
Module: process_instruction

Interface
REQ-001 Parameter REGISTER_NAME_WIDTH, default 4, gives the maximum characters in a register-name string.
REQ-002 Parameter IMMEDIATE_WIDTH, default 32, gives the signed immediate width.
REQ-003 Parameter FLAG_WIDTH, default 8, gives the decode flag width.
REQ-004 Parameter INSTRUCTION_NAME_WIDTH, default 12, gives the maximum characters in a mnemonic string.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 instruction  input  32  raw RV64 instruction word, little-endian bit order as fetched.
REQ-008 rd  output  REGISTER_NAME_WIDTH*8+1  destination register ABI name, ASCII, right-justified, zero-padded.
REQ-009 rs1  output  REGISTER_NAME_WIDTH*8+1  source-1 ABI name, same encoding.
REQ-010 rs2  output  REGISTER_NAME_WIDTH*8+1  source-2 ABI name, same encoding.
REQ-011 imm  output  IMMEDIATE_WIDTH, signed  decoded, sign-extended immediate.
REQ-012 flag  output  FLAG_WIDTH  decode flags.
REQ-013 instruction_name  output  INSTRUCTION_NAME_WIDTH*8+1  lowercase mnemonic, ASCII, right-justified, zero-padded.

Function
REQ-014 Outputs SHALL be registered: the decode of instruction sampled at rising edge N SHALL appear on the outputs after edge N and hold until the next edge; latency is 1 cycle.
REQ-015 The block SHALL decode RV64I and RV64M: lui, auipc, jal, jalr, beq, bne, blt, bge, bltu, bgeu, lb, lh, lw, ld, lbu, lhu, lwu, sb, sh, sw, sd, addi, slti, sltiu, xori, ori, andi, slli, srli, srai, add, sub, sll, slt, sltu, xor, srl, sra, or, and, addiw, slliw, srliw, sraiw, addw, subw, sllw, srlw, sraw, fence, ecall, ebreak, mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw, remuw.
REQ-016 Register names SHALL be ABI names x0..x31 = zero, ra, sp, gp, tp, t0-t2, s0, s1, a0-a7, s2-s11, t3-t6.
REQ-017 flag[2:0] SHALL encode the format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=none/illegal.
REQ-018 flag[3], flag[4], flag[5], flag[6] SHALL be set when rd, rs1, rs2 and imm, respectively, are meaningful; flag[7] SHALL be set for an illegal or unsupported encoding.
REQ-019 Unused register outputs SHALL be all-zero; imm SHALL be 0 when unused.
REQ-020 Immediates:
- I-type: inst[31:20], sign-extended.
- S-type: {inst[31:25], inst[11:7]}, sign-extended.
- B-type: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended.
- U-type: {inst[31:12], 12'b0}.
- J-type: {inst[31], inst[19:12], inst[20], inst[30:21], 0}, sign-extended.
REQ-021 Shift immediates SHALL be shamt only, zero-extended: slli/srli/srai use inst[25:20]; *w shifts use inst[24:20]. srai/sraiw are distinguished by inst[30].
REQ-022 ecall and ebreak SHALL report no registers and no immediate, with format code 1; fence SHALL report no registers and no immediate.
REQ-023 Any unmatched opcode, funct3 or funct7 combination, including 0x00000000, SHALL yield instruction_name "unknown", flag = 8'h87, and all other outputs zero.

Reset
REQ-024 While reset is high, all outputs SHALL be zero immediately, independent of clk.
REQ-025 After reset deasserts, the first rising edge SHALL load the decode of the current instruction.

Structure
REQ-026 A shared package SHALL hold the opcode, funct3 and funct7 constants, the format codes, the flag bit indices, and the ABI name table.
REQ-027 One sub-module, reg_name (5-bit index to ABI string, combinational), SHALL be instantiated three times; all other logic SHALL live in process_instruction.

Verification
REQ-028 0x00000013 -> "addi", rd "zero", rs1 "zero", imm 0, flag[2:0]=1, flag[3]=flag[4]=flag[6]=1, flag[5]=0.
REQ-029 0xfff00093 -> "addi", rd "ra", rs1 "zero", imm -1; 0x00b50533 -> "add", rd "a0", rs1 "a0", rs2 "a1", flag[2:0]=0.
REQ-030 0x00113423 -> "sd", rs1 "sp", rs2 "ra", imm 8, rd zero; 0x12345537 -> "lui", rd "a0", imm 0x12345000.
REQ-031 0xffdff06f -> "jal", rd "zero", imm -4, flag[2:0]=5; 0x02c58533 -> "mul", rd "a0", rs1 "a1", rs2 "a2".
REQ-032 0x00000000 -> "unknown", flag 8'h87; asserting reset between clock edges -> all outputs zero before the next edge.
